// File: rtl/as_pack.sv
// Shared definitions for the UART controller slice: byte width and TX FSM states.
package as_pack;

  localparam int uart_width = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } tx_state_t;

endpackage

// File: rtl/as_uart_ctrl_if.sv
// Host-side bus of the UART controller: two TX requesters plus the RX holding register.
interface as_uart_ctrl_if
  import as_pack::*;
#(
  parameter int FIFO_DEPTH = 4
) ();

  logic [1:0]                   tx_valid_i;
  logic [1:0][uart_width-1:0]   tx_data_i;
  logic [1:0]                   tx_ready_o;
  logic                         rx_valid_o;
  logic [uart_width-1:0]        rx_data_o;
  logic                         rx_read_i;
  logic                         rx_overrun_o;
  logic                         clear_i;
  logic [$clog2(FIFO_DEPTH):0]  tx_level_o;
  logic                         tx_busy_o;

  modport master (
    output tx_valid_i, tx_data_i, rx_read_i, clear_i,
    input  tx_ready_o, rx_valid_o, rx_data_o, rx_overrun_o, tx_level_o, tx_busy_o
  );

  modport slave (
    input  tx_valid_i, tx_data_i, rx_read_i, clear_i,
    output tx_ready_o, rx_valid_o, rx_data_o, rx_overrun_o, tx_level_o, tx_busy_o
  );

endinterface

// File: rtl/as_uart_fifo.sv
// Power-of-two TX FIFO with registered occupancy; full/empty derive from the level count.
module as_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   level;
  logic             do_push, do_pop;

  assign full_o     = (level == FULL_LEVEL);
  assign empty_o    = (level == '0);
  assign level_o    = level;
  assign pop_data_o = mem[rd_ptr];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (PTR_W + 1)'(1);
        2'b01:   level <= level - (PTR_W + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/as_uart_ctrl.sv
// UART controller: round-robin TX arbitration into a FIFO, a start/handshake FSM toward
// as_uart, and a single-byte RX holding register with sticky overrun.
module as_uart_ctrl
  import as_pack::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  as_uart_ctrl_if.slave         bus,
  output logic                  uart_start_o,
  output logic [uart_width-1:0] uart_data_o,
  input  logic                  uart_rdy_tx_i,
  input  logic                  uart_rdy_rx_i,
  input  logic [uart_width-1:0] uart_data_i
);

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_t             state_q, state_d;
  logic                  prio_q;
  logic [1:0]            grant;
  logic                  push, pop, fifo_full, fifo_empty;
  logic [uart_width-1:0] push_data, head_data;
  logic [LEVEL_W-1:0]    level;
  logic                  rdy_rx_q, capture;

  always_comb begin
    grant = 2'b00;
    if (bus.tx_valid_i == 2'b11) grant[prio_q] = 1'b1;
    else                         grant = bus.tx_valid_i;
  end

  assign bus.tx_ready_o = (rst_ni && !fifo_full) ? grant : 2'b00;
  assign push           = |bus.tx_ready_o;
  assign push_data      = grant[1] ? bus.tx_data_i[1] : bus.tx_data_i[0];

  // Pointer always moves to the requester that was not just served.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)   prio_q <= 1'b0;
    else if (push) prio_q <= grant[0];
  end

  as_uart_fifo #(
    .WIDTH (uart_width),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .pop_data_o  (head_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level)
  );

  assign bus.tx_level_o = level;
  assign bus.tx_busy_o  = (state_q != TX_IDLE) || !fifo_empty;

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    uart_start_o = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty && uart_rdy_tx_i) begin
          pop     = 1'b1;
          state_d = TX_START;
        end
      end
      TX_START: begin
        uart_start_o = 1'b1;
        state_d      = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: if (!uart_rdy_tx_i) state_d = TX_WAIT_DONE;
      TX_WAIT_DONE: if (uart_rdy_tx_i)  state_d = TX_IDLE;
      default:      state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= TX_IDLE;
      uart_data_o <= '0;
    end else begin
      state_q <= state_d;
      if (pop) uart_data_o <= head_data;
    end
  end

  // rdy_rx history resets high so a receiver already idling high cannot fake a capture.
  assign capture = uart_rdy_rx_i && !rdy_rx_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdy_rx_q         <= 1'b1;
      bus.rx_valid_o   <= 1'b0;
      bus.rx_data_o    <= '0;
      bus.rx_overrun_o <= 1'b0;
    end else begin
      rdy_rx_q <= uart_rdy_rx_i;
      if (capture) begin
        bus.rx_data_o  <= uart_data_i;
        bus.rx_valid_o <= 1'b1;
      end else if (bus.rx_read_i && bus.rx_valid_o) begin
        bus.rx_valid_o <= 1'b0;
      end
      if (capture && bus.rx_valid_o && !bus.rx_read_i) bus.rx_overrun_o <= 1'b1;
      else if (bus.clear_i)                             bus.rx_overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_as_uart_ctrl.sv
// Directed bench for as_uart_ctrl with a UART model that drops rdy_tx for 10 cycles after start.
module tb_as_uart_ctrl;
  import as_pack::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  uart_start;
  logic [uart_width-1:0] uart_data_out;
  logic [uart_width-1:0] uart_data_in;
  logic                  uart_rdy_tx;
  logic                  uart_rdy_rx;
  bit                    hold_busy = 1'b0;
  int                    busy_cnt = 0;
  logic [7:0]            tx_log [$];
  int                    n_checks = 0;
  int                    n_errors = 0;
  logic [7:0]            exp_fair [4];

  always #5 clk = ~clk;

  as_uart_ctrl_if #(.FIFO_DEPTH(4)) bus_if ();

  as_uart_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .bus           (bus_if),
    .uart_start_o  (uart_start),
    .uart_data_o   (uart_data_out),
    .uart_rdy_tx_i (uart_rdy_tx),
    .uart_rdy_rx_i (uart_rdy_rx),
    .uart_data_i   (uart_data_in)
  );

  // UART transmitter model: busy for 10 cycles after each sampled start, or held busy on demand.
  assign uart_rdy_tx = !hold_busy && (busy_cnt == 0);

  always @(posedge clk) begin
    if (uart_start) begin
      busy_cnt <= 10;
      tx_log.push_back(uart_data_out);
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int cycles = 0;
    while (bus_if.tx_busy_o && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
    check_output(tag, bus_if.tx_busy_o, 1'b0);
  endtask

  initial begin
    rst_n             = 1'b0;
    uart_rdy_rx       = 1'b0;
    uart_data_in      = '0;
    bus_if.tx_valid_i = 2'b00;
    bus_if.tx_data_i  = '0;
    bus_if.rx_read_i  = 1'b0;
    bus_if.clear_i    = 1'b0;
    exp_fair          = '{8'hA1, 8'hB1, 8'hA2, 8'hB2};

    // Reset state
    repeat (2) @(negedge clk);
    bus_if.tx_valid_i = 2'b11;
    #1;
    check_output("rst_ready", bus_if.tx_ready_o, 2'b00);
    bus_if.tx_valid_i = 2'b00;
    check_output("rst_start", uart_start, 1'b0);
    check_output("rst_udata", uart_data_out, 8'h00);
    check_output("rst_rxv", bus_if.rx_valid_o, 1'b0);
    check_output("rst_rxd", bus_if.rx_data_o, 8'h00);
    check_output("rst_ovr", bus_if.rx_overrun_o, 1'b0);
    check_output("rst_level", bus_if.tx_level_o, 3'd0);
    check_output("rst_busy", bus_if.tx_busy_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fairness: both requesters valid, grants alternate core/debug
    $display("[TB] fairness");
    bus_if.tx_valid_i   = 2'b11;
    bus_if.tx_data_i[0] = 8'hA1;
    bus_if.tx_data_i[1] = 8'hB1;
    #1 check_output("fair_g0", bus_if.tx_ready_o, 2'b01);
    @(negedge clk);
    bus_if.tx_data_i[0] = 8'hA2;
    #1 check_output("fair_g1", bus_if.tx_ready_o, 2'b10);
    @(negedge clk);
    bus_if.tx_data_i[1] = 8'hB2;
    #1 check_output("fair_g2", bus_if.tx_ready_o, 2'b01);
    @(negedge clk);
    bus_if.tx_valid_i = 2'b10;
    #1 check_output("fair_g3", bus_if.tx_ready_o, 2'b10);
    @(negedge clk);
    bus_if.tx_valid_i = 2'b00;
    wait_idle("fair_idle", 300);
    check_output("fair_cnt", tx_log.size(), 4);
    for (int i = 0; i < 4; i++) check_output($sformatf("fair_byte%0d", i), tx_log[i], exp_fair[i]);
    tx_log.delete();

    // Basic send: start observed on the second edge after acceptance
    $display("[TB] basic send");
    bus_if.tx_valid_i   = 2'b01;
    bus_if.tx_data_i[0] = 8'h55;
    #1 check_output("basic_ready", bus_if.tx_ready_o, 2'b01);
    @(negedge clk);
    bus_if.tx_valid_i = 2'b00;
    check_output("basic_start_c1", uart_start, 1'b0);
    check_output("basic_level", bus_if.tx_level_o, 3'd1);
    check_output("basic_busy", bus_if.tx_busy_o, 1'b1);
    @(negedge clk);
    check_output("basic_start_c2", uart_start, 1'b1);
    check_output("basic_data", uart_data_out, 8'h55);
    check_output("basic_level_pop", bus_if.tx_level_o, 3'd0);
    @(negedge clk);
    check_output("basic_pulse_end", uart_start, 1'b0);
    check_output("basic_data_hold", uart_data_out, 8'h55);
    check_output("basic_rdy_low", uart_rdy_tx, 1'b0);
    repeat (5) @(negedge clk);
    check_output("basic_busy_mid", bus_if.tx_busy_o, 1'b1);
    wait_idle("basic_idle", 40);
    check_output("basic_data_end", uart_data_out, 8'h55);
    check_output("basic_cnt", tx_log.size(), 1);
    check_output("basic_log", tx_log[0], 8'h55);
    tx_log.delete();

    // FIFO full with UART held busy
    $display("[TB] fifo full");
    hold_busy = 1'b1;
    bus_if.tx_valid_i = 2'b01;
    for (int i = 0; i < 4; i++) begin
      bus_if.tx_data_i[0] = 8'h10 + 8'(i);
      #1 check_output($sformatf("full_acc%0d", i), bus_if.tx_ready_o, 2'b01);
      @(negedge clk);
    end
    bus_if.tx_data_i[0] = 8'h14;
    #1 check_output("full_rdy5", bus_if.tx_ready_o, 2'b00);
    check_output("full_level", bus_if.tx_level_o, 3'd4);
    @(negedge clk);
    check_output("full_rdy5_hold", bus_if.tx_ready_o, 2'b00);
    hold_busy = 1'b0;
    #1 check_output("full_no_same_cycle", bus_if.tx_ready_o, 2'b00);
    @(negedge clk);
    check_output("full_level_pop", bus_if.tx_level_o, 3'd3);
    check_output("full_rdy_after_pop", bus_if.tx_ready_o, 2'b01);
    @(negedge clk);
    bus_if.tx_valid_i = 2'b00;
    check_output("full_level_refill", bus_if.tx_level_o, 3'd4);
    wait_idle("full_idle", 400);
    check_output("full_cnt", tx_log.size(), 5);
    for (int i = 0; i < 5; i++) check_output($sformatf("full_byte%0d", i), tx_log[i], 8'h10 + 8'(i));
    tx_log.delete();

    // RX capture and overrun
    $display("[TB] rx capture");
    uart_data_in = 8'h53;
    uart_rdy_rx  = 1'b1;
    @(negedge clk);
    check_output("rx_valid", bus_if.rx_valid_o, 1'b1);
    check_output("rx_data", bus_if.rx_data_o, 8'h53);
    check_output("rx_ovr0", bus_if.rx_overrun_o, 1'b0);
    uart_rdy_rx = 1'b0;
    @(negedge clk);
    uart_data_in = 8'h6A;
    uart_rdy_rx  = 1'b1;
    @(negedge clk);
    check_output("ovr_data", bus_if.rx_data_o, 8'h6A);
    check_output("ovr_flag", bus_if.rx_overrun_o, 1'b1);
    check_output("ovr_valid", bus_if.rx_valid_o, 1'b1);
    uart_rdy_rx    = 1'b0;
    bus_if.clear_i = 1'b1;
    @(negedge clk);
    bus_if.clear_i = 1'b0;
    check_output("clr_flag", bus_if.rx_overrun_o, 1'b0);
    check_output("clr_valid", bus_if.rx_valid_o, 1'b1);
    bus_if.rx_read_i = 1'b1;
    @(negedge clk);
    bus_if.rx_read_i = 1'b0;
    check_output("read_valid", bus_if.rx_valid_o, 1'b0);

    // Capture-with-overrun beats a same-cycle clear
    uart_data_in = 8'h11;
    uart_rdy_rx  = 1'b1;
    @(negedge clk);
    uart_rdy_rx = 1'b0;
    @(negedge clk);
    check_output("pre_ovr", bus_if.rx_overrun_o, 1'b0);
    uart_data_in   = 8'h22;
    uart_rdy_rx    = 1'b1;
    bus_if.clear_i = 1'b1;
    @(negedge clk);
    bus_if.clear_i = 1'b0;
    uart_rdy_rx    = 1'b0;
    check_output("clr_vs_ovr", bus_if.rx_overrun_o, 1'b1);
    check_output("clr_vs_data", bus_if.rx_data_o, 8'h22);
    bus_if.clear_i = 1'b1;
    @(negedge clk);
    bus_if.clear_i = 1'b0;
    check_output("clr2_flag", bus_if.rx_overrun_o, 1'b0);

    // Capture coinciding with a read
    uart_data_in     = 8'h7E;
    uart_rdy_rx      = 1'b1;
    bus_if.rx_read_i = 1'b1;
    @(negedge clk);
    bus_if.rx_read_i = 1'b0;
    check_output("sim_valid", bus_if.rx_valid_o, 1'b1);
    check_output("sim_data", bus_if.rx_data_o, 8'h7E);
    check_output("sim_ovr", bus_if.rx_overrun_o, 1'b0);

    // Reset in WAIT_BUSY with three bytes queued
    $display("[TB] reset mid-transmission");
    hold_busy = 1'b1;
    bus_if.tx_valid_i = 2'b01;
    for (int i = 0; i < 4; i++) begin
      bus_if.tx_data_i[0] = 8'h21 + 8'(i);
      @(negedge clk);
    end
    bus_if.tx_valid_i = 2'b00;
    check_output("mid_level4", bus_if.tx_level_o, 3'd4);
    hold_busy = 1'b0;
    repeat (2) @(negedge clk);
    check_output("mid_level3", bus_if.tx_level_o, 3'd3);
    check_output("mid_udata", uart_data_out, 8'h21);
    check_output("mid_rdy_low", uart_rdy_tx, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    bus_if.tx_valid_i = 2'b11;
    #1 check_output("mid_rst_ready", bus_if.tx_ready_o, 2'b00);
    bus_if.tx_valid_i = 2'b00;
    check_output("mid_rst_level", bus_if.tx_level_o, 3'd0);
    check_output("mid_rst_busy", bus_if.tx_busy_o, 1'b0);
    check_output("mid_rst_start", uart_start, 1'b0);
    check_output("mid_rst_udata", uart_data_out, 8'h00);
    check_output("mid_rst_rxv", bus_if.rx_valid_o, 1'b0);
    check_output("mid_rst_rxd", bus_if.rx_data_o, 8'h00);
    check_output("mid_rst_ovr", bus_if.rx_overrun_o, 1'b0);
    tx_log.delete();
    rst_n = 1'b1;
    bus_if.tx_valid_i = 2'b11;
    #1 check_output("mid_ptr_core", bus_if.tx_ready_o, 2'b01);
    bus_if.tx_valid_i = 2'b00;
    repeat (20) @(negedge clk);
    check_output("mid_no_start", tx_log.size(), 0);
    check_output("mid_post_level", bus_if.tx_level_o, 3'd0);
    check_output("mid_no_capture", bus_if.rx_valid_o, 1'b0);
    bus_if.tx_valid_i   = 2'b01;
    bus_if.tx_data_i[0] = 8'h99;
    @(negedge clk);
    bus_if.tx_valid_i = 2'b00;
    wait_idle("mid_new_idle", 60);
    check_output("mid_new_cnt", tx_log.size(), 1);
    check_output("mid_new_byte", tx_log[0], 8'h99);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/as_uart_ctrl.md
AS_UART_CTRL -- requirements
Module: as_uart_ctrl

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the TX FIFO depth; legal values are powers of two, 2 to 16.
REQ-002 The block SHALL take the byte width uart_width from as_pack and have no local width parameter.
REQ-003 The block SHALL have the following ports:
- clk_i  in  1  single clock; all logic on its rising edge.
- rst_ni  in  1  reset; synchronous and active-low.
- tx_valid_i  in  2  per-requester byte valid (bit0 = core, bit1 = debug).
- tx_data_i  in  2 x uart_width  per-requester byte.
- tx_ready_o  out  2  per-requester accept; a byte transfers when valid and ready are both high.
- rx_valid_o  out  1  received byte held.
- rx_data_o  out  uart_width  held received byte.
- rx_read_i  in  1  consumer pops the held byte.
- rx_overrun_o  out  1  sticky overrun flag.
- clear_i  in  1  clears rx_overrun_o.
- tx_level_o  out  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy.
- tx_busy_o  out  1  TX FSM not in IDLE, or FIFO not empty.
- uart_start_o  out  1  drives as_uart start_i.
- uart_data_o  out  uart_width  drives as_uart data_i.
- uart_rdy_tx_i  in  1  from as_uart rdy_tx_o; high = transmitter idle.
- uart_rdy_rx_i  in  1  from as_uart rdy_rx_o; rises when a byte completes.
- uart_data_i  in  uart_width  from as_uart data_o.

Function
REQ-004 Arbitration SHALL be round-robin: when both requesters are valid, the one at the priority pointer is granted, and the pointer then moves to the other requester.
REQ-005 Arbitration grants:
- A single valid requester is granted regardless of the pointer, and the pointer then moves to the other requester.
- At most one byte is accepted per cycle.
- tx_ready_o is high only for the granted requester, and only when the FIFO is not full.
- tx_ready_o is combinational from valid, pointer and full.
REQ-006 A pop from a full FIFO in the same cycle SHALL NOT enable a write; full is evaluated before the pop.
REQ-007 The TX FIFO SHALL be first-in first-out, wrap its pointers modulo FIFO_DEPTH, and update tx_level_o one cycle after each push or pop (both in the same cycle leaves the level unchanged).
REQ-008 The TX FSM SHALL have four states:
- IDLE: when FIFO not empty and uart_rdy_tx_i = 1, pop the head into uart_data_o and go to START.
- START: uart_start_o = 1 for exactly this one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: wait for uart_rdy_tx_i = 0, then go to WAIT_DONE.
- WAIT_DONE: wait for uart_rdy_tx_i = 1, then go to IDLE.
REQ-009 uart_data_o SHALL hold its value from IDLE exit until the next pop.
REQ-010 Latency from a push into an empty FIFO with the UART idle SHALL be: uart_start_o high exactly 2 cycles after the accepting edge.
REQ-011 RX capture SHALL be as follows:
- A rising edge of uart_rdy_rx_i (registered previous value) captures uart_data_i into rx_data_o and sets rx_valid_o on the next cycle.
- rx_read_i with rx_valid_o = 1 clears rx_valid_o.
REQ-012 A capture while rx_valid_o = 1 and no same-cycle rx_read_i SHALL overwrite rx_data_o and set rx_overrun_o.
REQ-013 A capture coinciding with rx_read_i SHALL load the new byte, keep rx_valid_o = 1, and not flag overrun.
REQ-014 clear_i SHALL clear rx_overrun_o; a capture-with-overrun in the same cycle SHALL win.

Reset
REQ-015 While rst_ni = 0 at a clock edge, the block SHALL enter the following reset state:
- FSM in IDLE, FIFO empty, priority pointer = core.
- uart_start_o = 0 and uart_data_o = 0.
- rx_valid_o = 0, rx_data_o = 0, rx_overrun_o = 0, tx_level_o = 0, tx_busy_o = 0.
- tx_ready_o = 0 during reset.
- Registered previous uart_rdy_rx_i = 1, so that no spurious capture occurs.
REQ-016 A reset mid-transmission SHALL abandon the FIFO contents and FSM state; after release, the block SHALL wait in IDLE for uart_rdy_tx_i = 1.

Structure
REQ-017 as_pack SHALL hold uart_width and the TX FSM state enum type.
REQ-018 The TX FIFO SHALL be a separate sub-module, as_uart_fifo (parameters WIDTH and DEPTH; push, pop, full, empty and level ports); arbitration, FSM and RX logic stay in as_uart_ctrl.

Verification
REQ-019 The bench SHALL cover the following directed scenarios, with a UART model that drops rdy_tx for 10 cycles after start:
- Basic send: core sends 0x55 into an empty FIFO with rdy_tx = 1 -> uart_start_o high exactly 2 cycles later with uart_data_o = 0x55 held, a one-cycle pulse, and tx_busy_o falls once rdy_tx returns.
- Fairness: both requesters valid continuously, core streaming 0xA1, 0xA2 and debug 0xB1, 0xB2 -> transmit order 0xA1, 0xB1, 0xA2, 0xB2.
- FIFO full: FIFO_DEPTH = 4, UART held busy, five core bytes offered -> four accepted, tx_level_o = 4, tx_ready_o = 0 for the fifth until the first pop.
- RX capture and overrun: rdy_rx rises with data 0x53 -> rx_valid_o = 1 and rx_data_o = 0x53; a second rise with 0x6A and no read -> rx_data_o = 0x6A and rx_overrun_o = 1; then clear_i -> 0.
- Simultaneous RX capture and read: capture coincides with rx_read_i -> rx_valid_o stays 1 with the new byte and rx_overrun_o stays 0.
- Reset mid-transmission: rst_ni low for 2 cycles in WAIT_BUSY with 3 bytes queued -> all outputs at reset values, tx_level_o = 0, no uart_start_o until new data is pushed.
